osd_spi_ctrl: RTL and testbench
===============================

OSD_SPI_CTRL -- requirements
Module: osd_spi_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for SPI inputs (legal range 2..4).
REQ-002 SHALL have parameter ADDR_W, default 11, giving the OSD buffer address width (8 lines x 256 bytes).
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port SPI_SCK, input, 1, the SPI clock; asynchronous to clk_sys.
REQ-006 SHALL have port SPI_SS3, input, 1, the OSD chip select, active-low; asynchronous.
REQ-007 SHALL have port SPI_DI, input, 1, the SPI data, MSB first; asynchronous.
REQ-008 SHALL have port osd_enable, output, 1, the OSD overlay enable level.
REQ-009 SHALL have port wr_en, output, 1, a one-cycle OSD buffer write strobe.
REQ-010 SHALL have port wr_addr, output, ADDR_W, the OSD buffer write address.
REQ-011 SHALL have port wr_data, output, 8, the OSD buffer write byte.
REQ-012 SHALL have port busy, output, 1, high while a transaction is active (state not IDLE).

Function
REQ-013 SHALL pass SCK, SS3 and DI through SYNC_STAGES flops each, with equal depth; SCK rise = synced SCK 0->1 across one extra flop.
REQ-014 SHALL require clk_sys >= 4x SCK frequency; slower ratios are out of scope.
REQ-015 SHALL sample synced DI on each synced SCK rise while synced SS3 = 0, shifting MSB first into an 8-bit register with a 3-bit bit counter.
REQ-016 SHALL implement the states IDLE, CMD, DATA and SKIP.
REQ-017 IDLE: SHALL move to CMD on synced SS3 falling; the bit counter and shift register clear.
REQ-018 CMD: SHALL decode the byte on the 8th bit: 0x20-0x27 -> DATA with wr_addr = {cmd[2:0], 8'h00}; 0x40 -> osd_enable = 0, then SKIP; 0x41 -> osd_enable = 1, then SKIP; any other byte -> SKIP with no effect.
REQ-019 DATA: SHALL, on the 8th bit of each byte, drive wr_data = byte and pulse wr_en for exactly one clk_sys cycle, in the cycle after the completing SCK rise.
REQ-020 DATA: SHALL increment wr_addr[7:0] in the cycle after each wr_en, wrapping 0xFF -> 0x00; wr_addr[10:8] never changes within a transaction.
REQ-021 wr_addr and wr_data SHALL stay stable during wr_en and hold their value between writes.
REQ-022 SKIP: SHALL ignore all SCK edges until SS3 rises.
REQ-023 SHALL return to IDLE from any state within one cycle of synced SS3 rising; a partial byte SHALL be discarded with no wr_en and no enable change.
REQ-024 SHALL let SS3 falling while not in IDLE (rise and fall inside one sync window) start a fresh CMD.
REQ-025 If an SCK rise and SS3 rise arrive in the same synced cycle, SS3 SHALL win and that bit SHALL be dropped.
REQ-026 osd_enable SHALL persist across transactions; only commands 0x40/0x41 and reset change it.

Reset
REQ-027 reset_n low SHALL asynchronously force: state IDLE, osd_enable 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, synchronizers to SCK 0 / SS3 1 / DI 0.
REQ-028 Reset assertion mid-transaction SHALL abort with no write; after release, operation SHALL resume only at the next SS3 falling edge.

Structure
REQ-029 Package osd_pkg SHALL hold the state enum, opcode constants (CMD_WRITE_BASE 0x20, CMD_OSD_OFF 0x40, CMD_OSD_ON 0x41) and the line size 256.
REQ-030 Sub-module spi_sync SHALL provide the parameterised synchronizers and the SCK-rise/SS3-edge pulses; decode and the FSM stay in osd_spi_ctrl.

Verification
REQ-031 Command 0x41 then SS3 high -> osd_enable 1, no wr_en; then command 0x40 -> osd_enable 0.
REQ-032 Command 0x23 followed by bytes AA,55,0F -> three wr_en pulses at addresses 0x300, 0x301, 0x302 carrying data AA, 55, 0F.
REQ-033 Command 0x20 followed by 258 bytes -> the last two writes land at 0x000 and 0x001 (the address wraps); wr_addr[10:8] stays 0.
REQ-034 Command 0x21, one full byte, then 5 bits, then SS3 rises -> exactly one wr_en at 0x100; state IDLE and busy 0 within SYNC_STAGES+2 cycles.
REQ-035 Command 0x7E followed by 4 bytes -> no wr_en and osd_enable unchanged; reset_n pulsed low mid-byte -> all outputs 0 immediately.
REQ-036 With SCK running at clk_sys/4, random write payloads SHALL match a scoreboard; runs SHALL cover SYNC_STAGES of 2 and 3.

Source files
------------

// File: rtl/osd_pkg.sv
// osd_pkg: shared types and constants for the OSD SPI command controller.
//   - osd_state_e   : controller state encoding
//   - CMD_*         : command opcodes
//   - LINE_SIZE/_W  : bytes per OSD line and its address width
//   - is_write_cmd  : true for the eight line-write opcodes 0x20..0x27
package osd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_SKIP = 2'd3
  } osd_state_e;

  localparam logic [7:0] CMD_WRITE_BASE = 8'h20;
  localparam logic [7:0] CMD_OSD_OFF    = 8'h40;
  localparam logic [7:0] CMD_OSD_ON     = 8'h41;

  localparam int LINE_SIZE = 256;
  localparam int LINE_W    = $clog2(LINE_SIZE);

  // Low three bits of a write opcode select the line.
  function automatic logic is_write_cmd(input logic [7:0] b);
    return (b & 8'hF8) == CMD_WRITE_BASE;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: synchronizes the asynchronous SPI pins into clk_sys and derives
// single-cycle edge pulses.
//   clk_sys, reset_n      : system clock, async active-low reset
//   sck_i, ss_i, di_i     : raw SPI clock, chip select (active low), data
//   sck_rise_o            : one-cycle pulse on synced SCK 0->1
//   ss_fall_o, ss_rise_o  : one-cycle pulses on synced SS edges
//   ss_o, di_o            : synced SS and DI levels
// All three pins go through the same number of flops, so the synced DI seen
// together with sck_rise_o is the value present when SCK actually rose.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sck_i,
  input  logic ss_i,
  input  logic di_i,
  output logic sck_rise_o,
  output logic ss_fall_o,
  output logic ss_rise_o,
  output logic ss_o,
  output logic di_o
);

  logic [SYNC_STAGES-1:0] sck_q, ss_q, di_q;
  logic                   sck_prev_q, ss_prev_q;

  // Idle-bus values at reset: SCK low, SS deasserted, DI low.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_q      <= '0;
      ss_q       <= '1;
      di_q       <= '0;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b1;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      ss_q       <= {ss_q[SYNC_STAGES-2:0], ss_i};
      di_q       <= {di_q[SYNC_STAGES-2:0], di_i};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
      ss_prev_q  <= ss_q[SYNC_STAGES-1];
    end
  end

  assign ss_o       = ss_q[SYNC_STAGES-1];
  assign di_o       = di_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign ss_fall_o  = ~ss_q[SYNC_STAGES-1] & ss_prev_q;
  assign ss_rise_o  = ss_q[SYNC_STAGES-1] & ~ss_prev_q;

endmodule

// File: rtl/osd_spi_ctrl.sv
// osd_spi_ctrl: SPI slave that decodes OSD commands and writes the OSD line
// buffer.
//   clk_sys, reset_n         : system clock, async active-low reset
//   SPI_SCK, SPI_SS3, SPI_DI : SPI pins (mode 0, MSB first), asynchronous
//   osd_enable               : overlay enable, set/cleared by 0x41/0x40
//   wr_en, wr_addr, wr_data  : one-cycle buffer write port
//   busy                     : transaction in progress
// First byte of a transaction is the command; 0x20..0x27 streams the
// following bytes into line cmd[2:0], auto-incrementing within the line.
module osd_spi_ctrl
  import osd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 11
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS3,
  input  logic              SPI_DI,
  output logic              osd_enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  logic sck_rise, ss_fall, ss_rise, ss_s, di_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sck_i      (SPI_SCK),
    .ss_i       (SPI_SS3),
    .di_i       (SPI_DI),
    .sck_rise_o (sck_rise),
    .ss_fall_o  (ss_fall),
    .ss_rise_o  (ss_rise),
    .ss_o       (ss_s),
    .di_o       (di_s)
  );

  osd_state_e        state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bitcnt_q;
  logic              en_q, wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [7:0]        byte_d;
  logic              shifting;

  assign byte_d   = {shift_q[6:0], di_s};
  assign shifting = sck_rise && !ss_s && (state_q == S_CMD || state_q == S_DATA);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      en_q     <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      // Advance within the line after each write; the line bits never move.
      if (wr_en_q)
        addr_q[LINE_W-1:0] <= addr_q[LINE_W-1:0] + 1'b1;

      // SS edges outrank a coincident SCK rise: that bit is dropped and any
      // partial byte is simply forgotten.
      if (ss_rise) begin
        state_q  <= S_IDLE;
        shift_q  <= '0;
        bitcnt_q <= '0;
      end else if (ss_fall) begin
        state_q  <= S_CMD;
        shift_q  <= '0;
        bitcnt_q <= '0;
      end else if (shifting) begin
        shift_q  <= byte_d;
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          if (state_q == S_CMD) begin
            if (is_write_cmd(byte_d)) begin
              state_q <= S_DATA;
              addr_q  <= ADDR_W'({byte_d[2:0], {LINE_W{1'b0}}});
            end else begin
              state_q <= S_SKIP;
              if (byte_d == CMD_OSD_OFF)     en_q <= 1'b0;
              else if (byte_d == CMD_OSD_ON) en_q <= 1'b1;
            end
          end else begin
            data_q  <= byte_d;
            wr_en_q <= 1'b1;
          end
        end
      end
    end
  end

  assign osd_enable = en_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_osd_spi_ctrl.sv
// Bench for osd_spi_ctrl: two instances (SYNC_STAGES 2 and 3) share one SPI
// bus running at clk_sys/4. Writes from each are captured into queues and
// compared with a transaction-level model of the command protocol.
module tb_osd_spi_ctrl;

  logic clk_sys = 1'b0;
  logic reset_n, SPI_SCK, SPI_SS3, SPI_DI;
  logic en2, wr2, busy2, en3, wr3, busy3;
  logic [10:0] a2, a3;
  logic [7:0]  d2, d3;

  always #5 clk_sys = ~clk_sys;

  osd_spi_ctrl #(.SYNC_STAGES(2), .ADDR_W(11)) u2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3),
    .SPI_DI(SPI_DI), .osd_enable(en2), .wr_en(wr2), .wr_addr(a2), .wr_data(d2),
    .busy(busy2));

  osd_spi_ctrl #(.SYNC_STAGES(3), .ADDR_W(11)) u3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3),
    .SPI_DI(SPI_DI), .osd_enable(en3), .wr_en(wr3), .wr_addr(a3), .wr_data(d3),
    .busy(busy3));

  typedef struct packed { logic [10:0] a; logic [7:0] d; } wr_t;

  wr_t        q2[$], q3[$], expq[$];
  logic [7:0] tx[$];
  logic       exp_en;
  int         vecs = 0, errs = 0;

  always @(negedge clk_sys) begin
    if (wr2) q2.push_back('{a2, d2});
    if (wr3) q3.push_back('{a3, d3});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_q(input string nm, input wr_t got[$], input wr_t exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({nm, "_write"}, 32'(got[i]), 32'(exp[i]));
  endtask

  // Protocol model: first byte is the command, rest is payload.
  task automatic model();
    expq.delete();
    if (tx.size() == 0) return;
    if (tx[0] >= 8'h20 && tx[0] <= 8'h27) begin
      for (int k = 1; k < tx.size(); k++)
        expq.push_back('{11'((tx[0] - 8'h20) * 256 + (k - 1) % 256), tx[k]});
    end else if (tx[0] == 8'h40) exp_en = 1'b0;
    else if (tx[0] == 8'h41)     exp_en = 1'b1;
  endtask

  task automatic spi_bit(input logic b);
    SPI_DI = b; #20; SPI_SCK = 1'b1; #20; SPI_SCK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  // Raise SS and confirm each instance is idle within SYNC_STAGES+2 cycles.
  task automatic ss_release();
    #40; SPI_SS3 = 1'b1;
    #40; chk("busy_clear_s2", busy2, 0);
    #10; chk("busy_clear_s3", busy3, 0);
    #40;
  endtask

  task automatic txn(input int tail);
    SPI_SS3 = 1'b0; #40;
    chk("busy_set_s2", busy2, 1);
    chk("busy_set_s3", busy3, 1);
    foreach (tx[i]) spi_byte(tx[i]);
    for (int i = 0; i < tail; i++) spi_bit(1'($urandom_range(0, 1)));
    ss_release();
    model();
  endtask

  task automatic verify(input string nm);
    cmp_q({nm, "_s2"}, q2, expq);
    cmp_q({nm, "_s3"}, q3, expq);
    chk({nm, "_en_s2"}, en2, exp_en);
    chk({nm, "_en_s3"}, en3, exp_en);
    q2.delete(); q3.delete();
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          nd;
    logic [7:0]  d [4];
    int          tail;
    int          exp_nwr;
    logic [10:0] exp_a0;
    logic        exp_en;
  } vec_t;

  vec_t tv[8];

  initial begin
    tv[0] = '{8'h41, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 11'h000, 1'b1};
    tv[1] = '{8'h40, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 11'h000, 1'b0};
    tv[2] = '{8'h41, 2, '{8'h11, 8'h22, 8'h00, 8'h00}, 0, 0, 11'h000, 1'b1};
    tv[3] = '{8'h23, 3, '{8'hAA, 8'h55, 8'h0F, 8'h00}, 0, 3, 11'h300, 1'b1};
    tv[4] = '{8'h21, 1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 5, 1, 11'h100, 1'b1};
    tv[5] = '{8'h7E, 4, '{8'h41, 8'h40, 8'h20, 8'hFF}, 0, 0, 11'h000, 1'b1};
    tv[6] = '{8'h27, 2, '{8'hC3, 8'h3C, 8'h00, 8'h00}, 3, 2, 11'h700, 1'b1};
    tv[7] = '{8'h40, 1, '{8'h99, 8'h00, 8'h00, 8'h00}, 0, 0, 11'h000, 1'b0};

    reset_n = 1'b0; SPI_SCK = 1'b0; SPI_SS3 = 1'b1; SPI_DI = 1'b0;
    exp_en = 1'b0;
    #22;
    chk("rst_out_s2", {en2, wr2, a2, d2, busy2}, 0);
    chk("rst_out_s3", {en3, wr3, a3, d3, busy3}, 0);
    reset_n = 1'b1;
    #40;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      tx.delete();
      tx.push_back(tv[v].cmd);
      for (int k = 0; k < tv[v].nd; k++) tx.push_back(tv[v].d[k]);
      txn(tv[v].tail);
      chk("tbl_nwr_s2", q2.size(), tv[v].exp_nwr);
      chk("tbl_nwr_s3", q3.size(), tv[v].exp_nwr);
      if (tv[v].exp_nwr > 0) begin
        chk("tbl_addr0_s2", q2.size() > 0 ? q2[0].a : 11'h7FF, tv[v].exp_a0);
        chk("tbl_addr0_s3", q3.size() > 0 ? q3[0].a : 11'h7FF, tv[v].exp_a0);
      end
      chk("tbl_en_s2", en2, tv[v].exp_en);
      chk("tbl_en_s3", en3, tv[v].exp_en);
      verify("tbl");
    end

    // Line wrap: 258 bytes into line 0
    tx.delete();
    tx.push_back(8'h20);
    for (int k = 0; k < 258; k++) tx.push_back(8'($urandom));
    txn(0);
    chk("wrap_cnt", q2.size(), 258);
    if (q2.size() == 258) begin
      chk("wrap_a256", q2[256].a, 11'h000);
      chk("wrap_a257", q2[257].a, 11'h001);
    end
    verify("wrap");

    // Reset mid-byte with overlay on
    tx.delete(); tx.push_back(8'h41); txn(0); verify("pre_rst");
    SPI_SS3 = 1'b0; #40;
    spi_byte(8'h22);
    spi_byte(8'hE7);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_s2", {en2, wr2, a2, d2, busy2}, 0);
    chk("midrst_s3", {en3, wr3, a3, d3, busy3}, 0);
    #19; SPI_SS3 = 1'b1;
    #20; reset_n = 1'b1;
    #60;
    // Only the write that completed before reset may appear
    exp_en = 1'b0;
    expq.delete(); expq.push_back('{11'h200, 8'hE7});
    verify("midrst");

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      int r;
      r = $urandom_range(0, 9);
      tx.delete();
      if (r < 6)       tx.push_back(8'h20 + 8'($urandom_range(0, 7)));
      else if (r == 6) tx.push_back(8'h40);
      else if (r == 7) tx.push_back(8'h41);
      else             tx.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < $urandom_range(0, 6); k++) tx.push_back(8'($urandom));
      txn($urandom_range(0, 7));
      verify("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
